note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/music_pkg.sv | 34 +++
 rtl/note_timer.sv | 37 +++
 rtl/note_sequencer.sv | 164 ++++++++++++++++
 tb/tb_note_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// ============================================================================
// Module : music_pkg
// Brief  : Shared state encoding, tape-code constants and note-length helper
//          for the note sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package music_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_PLAY  = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [5:0] END_CODE  = 6'd63;
    localparam logic [5:0] REST_CODE = 6'd0;

    localparam logic [1:0] DUR_WHOLE   = 2'd0;
    localparam logic [1:0] DUR_HALF    = 2'd1;
    localparam logic [1:0] DUR_QUARTER = 2'd2;
    localparam logic [1:0] DUR_EIGHTH  = 2'd3;

    // Each step of the duration select halves the note length.
    function automatic logic [31:0] note_cycles(input logic [31:0] clk_hz,
                                                input logic [1:0]  sel);
        return clk_hz >> sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/note_timer.sv
// ============================================================================
// Module : note_timer
// Brief  : 32-bit down-counter with clear, load, enable and zero flag; times
//          both the sounding and the articulation-gap part of a note.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module note_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    input  logic        i_en,
    output logic        o_zero
);

    logic [31:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 32'd0;
        end else if (i_clr) begin
            r_count <= 32'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != 32'd0)) begin
            r_count <= r_count - 32'd1;
        end
    end

    assign o_zero = (r_count == 32'd0);

endmodule

`default_nettype wire

// File: rtl/note_sequencer.sv
// ============================================================================
// Module : note_sequencer
// Brief  : Reads note codes from a tape stream and sequences note / gap /
//          end-of-song timing for the downstream scale and PWM path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module note_sequencer
    import music_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned GAP_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       play_en,
    input  logic       restart,
    input  logic       code_valid,
    input  logic [7:0] code,
    output logic       code_ready,
    output logic [5:0] note_idx,
    output logic [1:0] note_dur,
    output logic       note_strobe,
    output logic       song_end,
    output logic [7:0] underrun_cnt
);

    localparam logic [31:0] C_CLK_HZ  = 32'(CLK_HZ);
    localparam logic [31:0] C_GAP_DIV = 32'(GAP_DIV);

    state_t      r_state;
    logic [5:0]  r_cur_idx;
    logic [5:0]  r_note_idx;
    logic [1:0]  r_note_dur;
    logic        r_strobe;
    logic        r_song_end;
    logic [7:0]  r_underrun;
    logic [31:0] r_gap_len;
    logic        r_first_fetch;

    logic [5:0]  w_code_idx;
    logic [1:0]  w_code_dur;
    logic        w_code_ready;
    logic        w_accept;
    logic [31:0] w_dur_len;
    logic [31:0] w_gap_len;
    logic        w_tmr_zero;
    logic        w_tmr_en;
    logic        w_tmr_load;
    logic [31:0] w_tmr_val;
    logic        w_play_last;
    logic        w_gap_last;

    assign w_code_idx   = code[7:2];
    assign w_code_dur   = code[1:0];
    assign w_code_ready = (r_state == ST_FETCH) && play_en && !restart;
    assign w_accept     = code_valid && w_code_ready;

    assign w_dur_len = note_cycles(C_CLK_HZ, w_code_dur);
    assign w_gap_len = w_dur_len / C_GAP_DIV;

    assign w_play_last = (r_state == ST_PLAY) && play_en && w_tmr_zero;
    assign w_gap_last  = (r_state == ST_GAP)  && play_en && w_tmr_zero;

    // Loaded with length-1 so the terminal cycle is the one seen at zero.
    assign w_tmr_en   = play_en && ((r_state == ST_PLAY) || (r_state == ST_GAP));
    assign w_tmr_load = (w_accept && (w_code_idx != END_CODE)) ||
                        (w_play_last && (r_gap_len != 32'd0));
    assign w_tmr_val  = (r_state == ST_FETCH) ? (w_dur_len - w_gap_len - 32'd1)
                                              : (r_gap_len - 32'd1);

    note_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (restart),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_FETCH;
            r_cur_idx     <= REST_CODE;
            r_note_idx    <= REST_CODE;
            r_note_dur    <= DUR_WHOLE;
            r_strobe      <= 1'b0;
            r_song_end    <= 1'b0;
            r_underrun    <= 8'd0;
            r_gap_len     <= 32'd0;
            r_first_fetch <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (restart) begin
                r_state       <= ST_FETCH;
                r_note_idx    <= REST_CODE;
                r_song_end    <= 1'b0;
                r_first_fetch <= 1'b0;
            end else begin
                case (r_state)
                    ST_FETCH: begin
                        r_note_idx    <= REST_CODE;
                        r_first_fetch <= 1'b0;
                        if (r_first_fetch && !w_accept && (r_underrun != 8'hFF)) begin
                            r_underrun <= r_underrun + 8'd1;
                        end
                        if (w_accept) begin
                            if (w_code_idx == END_CODE) begin
                                r_state    <= ST_DONE;
                                r_song_end <= 1'b1;
                            end else begin
                                r_state    <= ST_PLAY;
                                r_cur_idx  <= w_code_idx;
                                r_note_idx <= w_code_idx;
                                r_note_dur <= w_code_dur;
                                r_strobe   <= 1'b1;
                                r_gap_len  <= w_gap_len;
                            end
                        end
                    end
                    ST_PLAY: begin
                        // Paused notes are muted but keep their place.
                        r_note_idx <= play_en ? r_cur_idx : REST_CODE;
                        if (w_play_last) begin
                            r_note_idx <= REST_CODE;
                            if (r_gap_len != 32'd0) begin
                                r_state <= ST_GAP;
                            end else begin
                                r_state       <= ST_FETCH;
                                r_first_fetch <= 1'b1;
                            end
                        end
                    end
                    ST_GAP: begin
                        r_note_idx <= REST_CODE;
                        if (w_gap_last) begin
                            r_state       <= ST_FETCH;
                            r_first_fetch <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        r_note_idx <= REST_CODE;
                        r_song_end <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_FETCH;
                    end
                endcase
            end
        end
    end

    assign code_ready   = w_code_ready;
    assign note_idx     = r_note_idx;
    assign note_dur     = r_note_dur;
    assign note_strobe  = r_strobe;
    assign song_end     = r_song_end;
    assign underrun_cnt = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_note_sequencer.sv
// ============================================================================
// Module : tb_note_sequencer
// Brief  : Directed self-checking bench for note_sequencer at CLK_HZ=800,
//          GAP_DIV=16 (whole note 800 cycles, 750 sounding + 50 gap).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_note_sequencer;

    logic       clk;
    logic       rst_n;
    logic       play_en;
    logic       restart;
    logic       code_valid;
    logic [7:0] code;
    logic       code_ready;
    logic [5:0] note_idx;
    logic [1:0] note_dur;
    logic       note_strobe;
    logic       song_end;
    logic [7:0] underrun_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n;

    note_sequencer #(
        .CLK_HZ  (800),
        .GAP_DIV (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .play_en      (play_en),
        .restart      (restart),
        .code_valid   (code_valid),
        .code         (code),
        .code_ready   (code_ready),
        .note_idx     (note_idx),
        .note_dur     (note_dur),
        .note_strobe  (note_strobe),
        .song_end     (song_end),
        .underrun_cnt (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic count_idx(input logic [5:0] v, output int cnt);
        cnt = 0;
        while ((note_idx === v) && (cnt < 5000)) begin
            cnt++;
            step();
        end
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while ((code_ready !== 1'b1) && (cnt < 5000)) begin
            cnt++;
            step();
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        play_en    = 1'b0;
        restart    = 1'b0;
        code_valid = 1'b0;
        code       = 8'h00;
        repeat (3) step();
        check("rst_note_idx", 32'(note_idx), 32'd0);
        check("rst_note_dur", 32'(note_dur), 32'd0);
        check("rst_strobe", 32'(note_strobe), 32'd0);
        check("rst_song_end", 32'(song_end), 32'd0);
        check("rst_underrun", 32'(underrun_cnt), 32'd0);
        check("rst_ready_paused", 32'(code_ready), 32'd0);
        rst_n   = 1'b1;
        play_en = 1'b1;
        #1;
        check("ready_after_rst", 32'(code_ready), 32'd1);

        // Whole note, index 11: 750 sounding + 50 gap cycles.
        code_valid = 1'b1; code = 8'h2C;
        step();
        code_valid = 1'b0; code = 8'h00;
        check("n1_strobe", 32'(note_strobe), 32'd1);
        check("n1_idx", 32'(note_idx), 32'd11);
        check("n1_dur", 32'(note_dur), 32'd0);
        check("n1_busy", 32'(code_ready), 32'd0);
        step();
        check("n1_strobe_once", 32'(note_strobe), 32'd0);
        count_idx(6'd11, n);
        check("n1_play_len", 32'(n), 32'd749);
        count_busy(n);
        check("n1_gap_len", 32'(n), 32'd50);
        check("n1_ready", 32'(code_ready), 32'd1);
        check("n1_underrun_pre", 32'(underrun_cnt), 32'd0);
        step();
        check("n1_underrun", 32'(underrun_cnt), 32'd1);

        // Eighth note, index 5: D=100, G=6.
        code_valid = 1'b1; code = 8'h17;
        step();
        code_valid = 1'b0;
        check("n2_strobe", 32'(note_strobe), 32'd1);
        check("n2_idx", 32'(note_idx), 32'd5);
        check("n2_dur", 32'(note_dur), 32'd3);
        count_idx(6'd5, n);
        check("n2_play_len", 32'(n), 32'd94);
        count_busy(n);
        check("n2_gap_len", 32'(n), 32'd6);

        // Rest code taken on the first FETCH cycle: timed normally, silent, no underrun.
        code_valid = 1'b1; code = 8'h03;
        step();
        code_valid = 1'b0;
        check("rest_strobe", 32'(note_strobe), 32'd1);
        check("rest_idx", 32'(note_idx), 32'd0);
        check("rest_dur", 32'(note_dur), 32'd3);
        check("rest_no_underrun", 32'(underrun_cnt), 32'd1);
        count_busy(n);
        check("rest_period", 32'(n), 32'd100);
        step();
        check("rest_underrun", 32'(underrun_cnt), 32'd2);

        // Pause at PLAY cycle 100 for 30 cycles.
        code_valid = 1'b1; code = 8'h2C;
        step();
        code_valid = 1'b0;
        repeat (99) step();
        check("pz_before", 32'(note_idx), 32'd11);
        play_en = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            check("pz_muted", 32'(note_idx), 32'd0);
        end
        play_en = 1'b1;
        step();
        count_idx(6'd11, n);
        check("pz_play_rest", 32'(n), 32'd650);
        count_busy(n);
        check("pz_gap_len", 32'(n), 32'd50);
        step();
        check("pz_underrun", 32'(underrun_cnt), 32'd3);

        // Restart at PLAY cycle 10 with a code offered alongside.
        code_valid = 1'b1; code = 8'h2C;
        step();
        code_valid = 1'b0;
        repeat (9) step();
        restart = 1'b1; code_valid = 1'b1; code = 8'h17;
        #1;
        check("rs_ready_low", 32'(code_ready), 32'd0);
        step();
        restart = 1'b0; code_valid = 1'b0;
        #1;
        check("rs_idx", 32'(note_idx), 32'd0);
        check("rs_no_strobe", 32'(note_strobe), 32'd0);
        check("rs_fetch", 32'(code_ready), 32'd1);
        step();
        check("rs_idle_strobe", 32'(note_strobe), 32'd0);
        check("rs_underrun", 32'(underrun_cnt), 32'd3);

        // End of song.
        code_valid = 1'b1; code = 8'hFC;
        step();
        code_valid = 1'b0;
        check("end_song_end", 32'(song_end), 32'd1);
        check("end_ready", 32'(code_ready), 32'd0);
        check("end_idx", 32'(note_idx), 32'd0);
        check("end_strobe", 32'(note_strobe), 32'd0);
        repeat (20) step();
        code_valid = 1'b1; code = 8'h2C;
        step();
        code_valid = 1'b0;
        check("end_hold", 32'(song_end), 32'd1);
        check("end_hold_ready", 32'(code_ready), 32'd0);
        check("end_ignore_code", 32'(note_strobe), 32'd0);
        restart = 1'b1;
        step();
        restart = 1'b0;
        #1;
        check("end_cleared", 32'(song_end), 32'd0);
        check("end_ready_back", 32'(code_ready), 32'd1);
        check("end_underrun", 32'(underrun_cnt), 32'd3);

        // 300 late-fed notes drive the underrun counter to saturation.
        for (int i = 0; i < 300; i++) begin
            code_valid = 1'b1; code = 8'h03;
            step();
            code_valid = 1'b0;
            count_busy(n);
            check("sat_period", 32'(n), 32'd100);
            step();
            if (i == 99) check("sat_mid", 32'(underrun_cnt), 32'd103);
        end
        check("sat_final", 32'(underrun_cnt), 32'd255);

        // Asynchronous reset mid-note.
        code_valid = 1'b1; code = 8'h2C;
        step();
        code_valid = 1'b0;
        repeat (5) step();
        check("ar_playing", 32'(note_idx), 32'd11);
        #2 rst_n = 1'b0;
        #1;
        check("ar_idx", 32'(note_idx), 32'd0);
        check("ar_underrun", 32'(underrun_cnt), 32'd0);
        check("ar_song_end", 32'(song_end), 32'd0);
        check("ar_dur", 32'(note_dur), 32'd0);
        code_valid = 1'b1; code = 8'h17;
        step();
        step();
        check("ar_no_accept", 32'(note_strobe), 32'd0);
        rst_n = 1'b1;
        #1;
        check("ar_ready", 32'(code_ready), 32'd1);
        step();
        code_valid = 1'b0;
        check("ar_first_strobe", 32'(note_strobe), 32'd1);
        check("ar_first_idx", 32'(note_idx), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
